cpu_mem_arbiter: RTL and testbench

//  Sits directly downstream of the multicycle RISC-V core. Merges its instruction-fetch channel and its data

---
 rtl/cpu_mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_pick.sv | 29 ++
 rtl/cpu_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_arb_pkg.sv
// Shared types for the CPU memory arbiter: one-hot FSM states, grant identifiers
// and default bus widths.
package cpu_mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_I_REQ   = 6'b000010,
        ST_I_RESP  = 6'b000100,
        ST_D_WR    = 6'b001000,
        ST_D_RREQ  = 6'b010000,
        ST_D_RRESP = 6'b100000
    } arb_state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way picker between fetch and data requests.
// Define DATA_PRIO_EN to make data win every tie; otherwise ties alternate round-robin.
module mem_arb_pick
    import cpu_mem_arb_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  grant_e last_grant,
    output logic   gnt_i,
    output logic   gnt_d
);

`ifdef DATA_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        gnt_d = req_d;
        gnt_i = req_i & ~req_d;
    end
`else
    // On a tie the side that did not win last time takes the bus.
    always_comb begin
        gnt_i = req_i & (~req_d | (last_grant == GRANT_D));
        gnt_d = req_d & (~req_i | (last_grant == GRANT_I));
    end
`endif

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Merges the core's fetch and load/store channels onto one memory bus, one transaction
// at a time. Tie policy is selected by DATA_PRIO_EN inside mem_arb_pick.
module cpu_mem_arbiter
    import cpu_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_rdata_valid,
    input  logic                i_rdata_ready,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_memwrite,
    input  logic                d_memread,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_req_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_rdata_valid,
    input  logic                d_rdata_ready,
    output logic [ADDR_W-1:0]   m_addr,
    output logic                m_memwrite,
    output logic                m_memread,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_req_ready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_rdata_valid,
    output logic                m_rdata_ready
);

    arb_state_e state_q, state_d;
    grant_e     last_grant_q, last_grant_d;
    logic       gnt_i, gnt_d;

    mem_arb_pick u_pick (
        .req_i      (i_req_valid),
        .req_d      (d_memread | d_memwrite),
        .last_grant (last_grant_q),
        .gnt_i      (gnt_i),
        .gnt_d      (gnt_d)
    );

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_D;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // NOTE: every output is defaulted before the case so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        i_req_ready   = 1'b0;
        i_rdata       = '0;
        i_rdata_valid = 1'b0;
        d_req_ready   = 1'b0;
        d_rdata       = '0;
        d_rdata_valid = 1'b0;
        m_addr        = '0;
        m_memwrite    = 1'b0;
        m_memread     = 1'b0;
        m_wdata       = '0;
        m_wstrb       = '0;
        m_rdata_ready = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_i) begin
                    state_d      = ST_I_REQ;
                    last_grant_d = GRANT_I;
                end else if (gnt_d) begin
                    // A simultaneous read+write request is treated as a write.
                    state_d      = d_memwrite ? ST_D_WR : ST_D_RREQ;
                    last_grant_d = GRANT_D;
                end
            end
            ST_I_REQ: begin
                m_addr      = i_addr;
                m_memread   = 1'b1;
                i_req_ready = m_req_ready;
                if (m_req_ready) state_d = ST_I_RESP;
            end
            ST_I_RESP: begin
                m_rdata_ready = i_rdata_ready;
                i_rdata       = m_rdata;
                i_rdata_valid = m_rdata_valid;
                if (m_rdata_valid && i_rdata_ready) state_d = ST_IDLE;
            end
            ST_D_WR: begin
                m_addr      = d_addr;
                m_memwrite  = 1'b1;
                m_wdata     = d_wdata;
                m_wstrb     = d_wstrb;
                d_req_ready = m_req_ready;
                if (m_req_ready) state_d = ST_IDLE;
            end
            ST_D_RREQ: begin
                m_addr      = d_addr;
                m_memread   = 1'b1;
                d_req_ready = m_req_ready;
                if (m_req_ready) state_d = ST_D_RRESP;
            end
            ST_D_RRESP: begin
                m_rdata_ready = d_rdata_ready;
                d_rdata       = m_rdata;
                d_rdata_valid = m_rdata_valid;
                if (m_rdata_valid && d_rdata_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed scenarios followed by randomized
// fetch/load/store traffic checked against a transaction-level model.
module tb_cpu_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef DATA_PRIO_EN
    localparam bit DATA_PRIO = 1'b1;
`else
    localparam bit DATA_PRIO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_addr;
    logic          i_req_valid, i_req_ready;
    logic [DW-1:0] i_rdata;
    logic          i_rdata_valid, i_rdata_ready;
    logic [AW-1:0] d_addr;
    logic          d_memwrite, d_memread;
    logic [DW-1:0] d_wdata;
    logic [SW-1:0] d_wstrb;
    logic          d_req_ready;
    logic [DW-1:0] d_rdata;
    logic          d_rdata_valid, d_rdata_ready;
    logic [AW-1:0] m_addr;
    logic          m_memwrite, m_memread;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic          m_req_ready;
    logic [DW-1:0] m_rdata;
    logic          m_rdata_valid, m_rdata_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
        .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid), .i_rdata_ready(i_rdata_ready),
        .d_addr(d_addr), .d_memwrite(d_memwrite), .d_memread(d_memread),
        .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_req_ready(d_req_ready),
        .d_rdata(d_rdata), .d_rdata_valid(d_rdata_valid), .d_rdata_ready(d_rdata_ready),
        .m_addr(m_addr), .m_memwrite(m_memwrite), .m_memread(m_memread),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_req_ready(m_req_ready),
        .m_rdata(m_rdata), .m_rdata_valid(m_rdata_valid), .m_rdata_ready(m_rdata_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic any_out();
        return |{i_req_ready, i_rdata, i_rdata_valid, d_req_ready, d_rdata, d_rdata_valid,
                 m_addr, m_memwrite, m_memread, m_wdata, m_wstrb, m_rdata_ready};
    endfunction

    // Who wins when the bus is free: a lone requester, or on a tie the one not served last.
    function automatic bit pick_data(bit f, bit d, bit last_was_d);
        if (DATA_PRIO) return d;
        return (f && d) ? !last_was_d : d;
    endfunction

    task automatic clear_inputs();
        i_addr = '0; i_req_valid = 0; i_rdata_ready = 0;
        d_addr = '0; d_memwrite = 0; d_memread = 0; d_wdata = '0; d_wstrb = '0; d_rdata_ready = 0;
        m_req_ready = 0; m_rdata = '0; m_rdata_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    // Random-phase state: requester agents, bus agent and transaction-level model.
    typedef enum {PH_FREE, PH_REQ, PH_RESP} phase_e;
    phase_e        ph, ph_next;
    bit            own_d, own_wr, last_d;
    bit            fa_pend, fa_wait, da_pend, da_wait, da_wr, bu_out;
    logic [AW-1:0] fa_addr, da_addr;
    logic [DW-1:0] da_wdata, bu_data;
    logic [SW-1:0] da_wstrb;
    int            bu_delay, n_done, n_g;
    logic [1:0]    grants [4];

    initial begin
        rst = 1'b0;
        clear_inputs();

        // Reset state: every output low.
        @(negedge clk); #1;
        check("reset_outputs", any_out(), 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Fetch without backpressure.
        @(negedge clk);
        i_req_valid = 1; i_addr = 32'h100; m_req_ready = 1;
        #1 check("t1_arb_no_ready", {i_req_ready, m_memread}, 2'b00);
        @(negedge clk); #1;
        check("t1_req_ready", i_req_ready, 1'b1);
        check("t1_bus_req", {m_memread, m_memwrite, m_addr}, {2'b10, 32'h100});
        @(negedge clk);
        i_req_valid = 0;
        #1 check("t1_wait_resp", i_rdata_valid, 1'b0);
        @(negedge clk);
        m_rdata_valid = 1; m_rdata = 32'h0000_0013; i_rdata_ready = 1;
        #1 check("t1_i_rdata", {i_rdata_valid, i_rdata}, {1'b1, 32'h13});
        check("t1_d_quiet", {d_req_ready, d_rdata_valid, d_rdata}, '0);
        check("t1_m_rready", m_rdata_ready, 1'b1);
        @(negedge clk);
        m_rdata_valid = 0; i_rdata_ready = 0;
        #1 check("t1_back_idle", any_out(), 1'b0);

        // Store: one bus cycle, then idle with no response phase.
        @(negedge clk);
        d_memwrite = 1; d_addr = 32'h2004; d_wdata = 32'hA5A5_A5A5; d_wstrb = 4'hC; m_req_ready = 1;
        #1 check("t2_arb_no_ready", {d_req_ready, m_memwrite}, 2'b00);
        @(negedge clk); #1;
        check("t2_bus_wr", {m_memwrite, m_memread, m_addr}, {2'b10, 32'h2004});
        check("t2_bus_wdata", {m_wstrb, m_wdata}, {4'hC, 32'hA5A5_A5A5});
        check("t2_d_req_ready", d_req_ready, 1'b1);
        @(negedge clk);
        d_memwrite = 0;
        #1 check("t2_idle_after", any_out(), 1'b0);

        // Tie held from reset: grant order alternates (or data always wins).
        @(negedge clk);
        rst = 1'b0;
        i_req_valid = 1; i_addr = 32'h5100; d_memread = 1; d_addr = 32'h5000;
        m_req_ready = 1; m_rdata_valid = 1; m_rdata = 32'h1; i_rdata_ready = 1; d_rdata_ready = 1;
        @(negedge clk);
        rst = 1'b1;
        n_g = 0;
        for (int k = 0; k < 4; k++) grants[k] = 2'b11;
        for (int c = 0; c < 40 && n_g < 4; c++) begin
            @(negedge clk); #1;
            if (i_req_ready || d_req_ready) begin
                grants[n_g] = {i_req_ready, d_req_ready};
                n_g++;
            end
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("t3_tie_order_%0d", k), grants[k],
                  (DATA_PRIO || (k % 2 == 1)) ? 2'b01 : 2'b10);

        // Load stalled by the bus for 5 cycles.
        do_reset();
        @(negedge clk);
        d_memread = 1; d_addr = 32'h3000; m_req_ready = 0;
        #1 check("t4_arb_no_ready", d_req_ready, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            check($sformatf("t4_stall_%0d", c), {d_req_ready, m_memread, m_addr}, {2'b01, 32'h3000});
        end
        @(negedge clk);
        m_req_ready = 1;
        #1 check("t4_accept", {d_req_ready, m_addr}, {1'b1, 32'h3000});
        @(negedge clk);
        d_memread = 0; m_rdata_valid = 1; m_rdata = 32'hCAFE_F00D; d_rdata_ready = 1;
        #1 check("t4_d_rdata", {i_rdata_valid, d_rdata_valid, d_rdata}, {2'b01, 32'hCAFE_F00D});
        @(negedge clk);
        clear_inputs();

        // Response backpressure from the fetch side.
        do_reset();
        @(negedge clk);
        i_req_valid = 1; i_addr = 32'h200; m_req_ready = 1;
        @(negedge clk); #1;
        check("t5_accept", i_req_ready, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            i_req_valid = 0; m_rdata_valid = 1; m_rdata = 32'h00B0_0093; i_rdata_ready = 0;
            #1 check($sformatf("t5_hold_%0d", c), {m_rdata_ready, i_rdata_valid}, 2'b01);
        end
        @(negedge clk);
        i_rdata_ready = 1;
        #1 check("t5_release", {m_rdata_ready, i_rdata}, {1'b1, 32'h00B0_0093});
        @(negedge clk); #1;
        check("t5_exited", {m_rdata_ready, i_rdata_valid}, 2'b00);
        clear_inputs();

        // Asynchronous reset in the middle of a load response.
        do_reset();
        @(negedge clk);
        d_memread = 1; d_addr = 32'h4000; m_req_ready = 1;
        @(negedge clk); #1;
        check("t6_accept", d_req_ready, 1'b1);
        @(negedge clk);
        d_memread = 0; m_rdata_valid = 1; m_rdata = 32'h1234_5678; d_rdata_ready = 1;
        #1 check("t6_in_resp", d_rdata_valid, 1'b1);
        #1 rst = 1'b0;
        #1 check("t6_async_clear", any_out(), 1'b0);
        i_req_valid = 1; d_memread = 1; m_rdata_valid = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        check("t6_tie_after_reset", {i_req_ready, d_req_ready}, DATA_PRIO ? 2'b01 : 2'b10);
        clear_inputs();

        // Randomized traffic against the transaction-level model.
        do_reset();
        ph = PH_FREE; last_d = 1; n_done = 0;
        fa_pend = 0; fa_wait = 0; da_pend = 0; da_wait = 0; da_wr = 0; bu_out = 0; bu_delay = 0;
        fa_addr = '0; da_addr = '0; da_wdata = '0; da_wstrb = '0; bu_data = '0;
        own_d = 0; own_wr = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (!fa_pend && !fa_wait && $urandom_range(0, 2) == 0) begin
                fa_pend = 1; fa_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!da_pend && !da_wait && $urandom_range(0, 2) == 0) begin
                da_pend = 1; da_wr = 1'($urandom_range(0, 1));
                da_addr = $urandom & 32'hFFFF_FFFC; da_wdata = $urandom;
                da_wstrb = 4'($urandom_range(0, 15));
            end
            i_req_valid   = fa_pend;  i_addr  = fa_addr;
            d_memread     = da_pend && !da_wr;
            d_memwrite    = da_pend && da_wr;
            d_addr        = da_addr;  d_wdata = da_wdata; d_wstrb = da_wstrb;
            i_rdata_ready = 1'($urandom_range(0, 1));
            d_rdata_ready = 1'($urandom_range(0, 1));
            m_req_ready   = ($urandom_range(0, 2) != 0);
            m_rdata_valid = bu_out && (bu_delay == 0);
            m_rdata       = m_rdata_valid ? bu_data : $urandom;
            #1;
            ph_next = ph;
            case (ph)
                PH_FREE: begin
                    check("idle_quiet", {i_req_ready, d_req_ready, m_rdata_ready, i_rdata_valid,
                                         d_rdata_valid, m_memread, m_memwrite}, '0);
                    check("idle_rdata_zero", {i_rdata, d_rdata}, '0);
                    if (fa_pend || da_pend) begin
                        own_d   = pick_data(fa_pend, da_pend, last_d);
                        last_d  = own_d;
                        own_wr  = own_d && da_wr;
                        ph_next = PH_REQ;
                    end
                end
                PH_REQ: begin
                    check("req_kind", {m_memwrite, m_memread}, own_wr ? 2'b10 : 2'b01);
                    check("req_addr", m_addr, own_d ? da_addr : fa_addr);
                    check("req_ready_route", {i_req_ready, d_req_ready},
                          own_d ? {1'b0, m_req_ready} : {m_req_ready, 1'b0});
                    if (m_req_ready) begin
                        if (own_wr) begin
                            check("req_wdata", {m_wstrb, m_wdata}, {da_wstrb, da_wdata});
                            da_pend = 0; n_done++; ph_next = PH_FREE;
                        end else begin
                            if (own_d) begin da_pend = 0; da_wait = 1; end
                            else       begin fa_pend = 0; fa_wait = 1; end
                            bu_out = 1; bu_delay = $urandom_range(0, 4); bu_data = $urandom;
                            ph_next = PH_RESP;
                        end
                    end
                end
                PH_RESP: begin
                    check("rready_route", m_rdata_ready, own_d ? d_rdata_ready : i_rdata_ready);
                    if (m_rdata_valid && m_rdata_ready) begin
                        if (own_d) begin
                            check("d_resp", {i_rdata_valid, d_rdata_valid, d_rdata}, {2'b01, bu_data});
                            da_wait = 0;
                        end else begin
                            check("i_resp", {d_rdata_valid, i_rdata_valid, i_rdata}, {2'b01, bu_data});
                            fa_wait = 0;
                        end
                        bu_out = 0; n_done++; ph_next = PH_FREE;
                    end else if (bu_out && bu_delay > 0) begin
                        bu_delay--;
                    end
                end
                default: ph_next = PH_FREE;
            endcase
            ph = ph_next;
        end
        @(negedge clk);
        clear_inputs();
        check("rand_progress", (n_done > 50), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
